// File: rtl/key_debounce.sv
// key_debounce
//   Per-channel input conditioning for raw board push-buttons and switches:
//   a synchroniser chain, a stable-time debounce counter, a registered clean
//   level and one-cycle press / release strobes. Channels share no state.
//
//   Handshake: none. key_in is free-running and asynchronous. key_level is a
//   registered level. key_press / key_release are registered single-cycle
//   strobes that coincide with the first cycle key_level shows the new value.
//
//   Build option (macro KEY_ACTIVE_LOW_EN):
//     defined   - key_in is inverted ahead of the first synchroniser flop, so
//                 an idle pulled-high button reads key_level = 0.
//     undefined - key_in is used as-is (high level = pressed).
//
//   Parameter constraints: SYNC_STAGES >= 2, STABLE_CYCLES >= 2,
//   2**CNT_W > STABLE_CYCLES.
//
//   Per-channel state is visible for checkers as gen_ch[i].state
//   (CH_IDLE / CH_COUNTING), gen_ch[i].cnt_q and gen_ch[i].db_q.

module key_debounce #(
   parameter int CHANNELS      = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_W         = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] key_in,
   output logic [CHANNELS-1:0] key_level,
   output logic [CHANNELS-1:0] key_press,
   output logic [CHANNELS-1:0] key_release
);

   // Debounce phase of one channel. It is a pure decode of (s != db), so it
   // needs no register of its own; it exists so checkers and the next-state
   // logic talk about the same named phase.
   typedef enum logic {
      CH_IDLE     = 1'b0,
      CH_COUNTING = 1'b1
   } ch_state_e;

   // Counter value on which a persisting mismatch is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Polarity-corrected raw input; the only consumer of key_in.
   logic [CHANNELS-1:0] key_raw;

`ifdef KEY_ACTIVE_LOW_EN
   // Active-low buttons: invert before synchronising so "pressed" is 1
   // everywhere downstream and the all-zero reset state means "idle".
   assign key_raw = ~key_in;
`else
   // Active-high buttons: a high level already means pressed.
   assign key_raw = key_in;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch

      // Synchroniser chain; bit 0 is the first flop, the top bit is s.
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;
      logic                   s;

      // Debounce state.
      ch_state_e              state;
      logic                   at_last;
      logic [CNT_W-1:0]       cnt_q;
      logic [CNT_W-1:0]       cnt_d;
      logic                   db_q;
      logic                   db_d;
      logic                   press_q;
      logic                   press_d;
      logic                   release_q;
      logic                   release_d;

      assign s = sync_q[SYNC_STAGES-1];

      // Shift the raw level one stage deeper into the synchroniser each cycle.
      always_comb begin
         sync_d = {sync_q[SYNC_STAGES-2:0], key_raw[i]};
      end

      // Register the synchroniser chain; reset clears every stage.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '0;
         end else begin
            sync_q <= sync_d;
         end
      end

      // Decode the debounce phase and the "stable period elapsed" condition.
      always_comb begin
         state   = (s == db_q) ? CH_IDLE : CH_COUNTING;
         at_last = (cnt_q == CNT_LAST);
      end

      // Next-state for counter, debounced level and strobes. Any cycle with
      // s == db sends the counter back to zero, so a glitch restarts the
      // whole stable period instead of resuming a partial count.
      always_comb begin
         cnt_d     = '0;
         db_d      = db_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         case (state)
            CH_IDLE: begin
               cnt_d = '0;
            end
            CH_COUNTING: begin
               if (at_last) begin
                  // Mismatch persisted long enough: accept s and strobe the
                  // direction of the change. Counter clears, so it never
                  // saturates and the next episode starts from zero.
                  db_d      = s;
                  cnt_d     = '0;
                  press_d   = s;
                  release_d = ~s;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               cnt_d = '0;
            end
         endcase
      end

      // Register counter, level and strobes; reset discards any partial count
      // and suppresses strobes.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q     <= '0;
            db_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      assign key_level[i]   = db_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;

   end : gen_ch

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Bench for key_debounce with CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=8,
//   CNT_W=4. Expected strobe events {cycle, press, release, level} are queued
//   when stimulus is driven and popped by a monitor when strobes appear.
//   Stimulus values are written in "pressed = 1" terms and converted to the
//   board polarity selected by KEY_ACTIVE_LOW_EN.

`timescale 1ns/1ps

module tb_key_debounce;

   localparam int CH     = 2;
   localparam int SYNC   = 2;
   localparam int STABLE = 8;
   localparam int CW     = 4;
   localparam int LAT    = SYNC + STABLE;
   localparam int EW     = 38;   // {cycle[31:0], press[1:0], release[1:0], level[1:0]}

`ifdef KEY_ACTIVE_LOW_EN
   localparam logic [1:0] POL = 2'b11;
`else
   localparam logic [1:0] POL = 2'b00;
`endif

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] key_in;
   logic [CH-1:0] key_level;
   logic [CH-1:0] key_press;
   logic [CH-1:0] key_release;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_pass = 0;
   bit            mon_en = 1'b0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;

   always #5 clk = ~clk;

   // Cycle index: edge k after time zero makes cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   key_debounce #(
      .CHANNELS      (CH),
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STABLE),
      .CNT_W         (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
   endtask

   task automatic check_level(input string tag, input logic [1:0] v);
      check(tag, {30'd0, key_level}, {30'd0, v});
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {26'd0, key_level, key_press, key_release}, 32'd0);
   endtask

   // ---------------- driver tasks ----------------
   // Change the keys 2 ns after the next rising edge; the following edge is
   // the first one that samples the new value.
   task automatic set_keys(input logic [1:0] v);
      @(posedge clk);
      #2;
      key_in = v ^ POL;
   endtask

   // Expect a strobe LAT edges after the most recent set_keys call.
   task automatic expect_strobe(input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
      exp_q.push_back({32'(cyc + LAT), p, r, l});
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if ((key_press | key_release) != 2'b00) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {28'd0, key_press, key_release}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("strobe_cycle", 32'(cyc), mon_e[37:6]);
               check("strobe_value", {28'd0, key_press, key_release}, {28'd0, mon_e[5:2]});
               check("level_at_strobe", {30'd0, key_level}, {30'd0, mon_e[1:0]});
            end
         end else if (exp_q.size() != 0) begin
            mon_e = exp_q[0];
            if (mon_e[37:6] <= 32'(cyc)) begin
               void'(exp_q.pop_front());
               check("missing_strobe", {28'd0, key_press, key_release}, {28'd0, mon_e[5:2]});
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   logic [1:0] bounce [4] = '{2'b11, 2'b01, 2'b11, 2'b01};

   initial begin
      // 1. Reset held with raw inputs high: all outputs stay 0.
      key_in = 2'b11;
      rst_n  = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_all_zero("rst_hold");
      end
      key_in = 2'b00 ^ POL;
      @(negedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      wait_edges(4);
      @(negedge clk);
      check_all_zero("idle_after_rst");

      // 2. Clean press on channel 0.
      set_keys(2'b01);
      expect_strobe(2'b01, 2'b00, 2'b01);
      wait_edges(LAT - 1);
      @(negedge clk);
      check_level("press_edge_before", 2'b00);
      wait_edges(1);
      @(negedge clk);
      check_level("press_edge", 2'b01);
      wait_edges(4);
      @(negedge clk);
      check("ch1_quiet", {29'd0, key_level[1], key_press[1], key_release[1]}, 32'd0);
      check_level("press_hold", 2'b01);

      // 3. Bounce on channel 1 with 3-cycle dwell, then held high.
      for (int k = 0; k < 4; k++) begin
         set_keys(bounce[k]);
         wait_edges(2);
      end
      set_keys(2'b11);
      expect_strobe(2'b10, 2'b00, 2'b11);
      wait_edges(LAT - 1);
      @(negedge clk);
      check_level("bounce_edge_before", 2'b01);
      wait_edges(4);
      @(negedge clk);
      check_level("bounce_settled", 2'b11);

      // 4. 5-cycle low glitch on channel 0 is rejected.
      set_keys(2'b10);
      wait_edges(4);
      set_keys(2'b11);
      wait_edges(LAT + 4);
      @(negedge clk);
      check_level("glitch_level", 2'b11);

      // 5. Simultaneous release on both channels.
      set_keys(2'b00);
      expect_strobe(2'b00, 2'b11, 2'b00);
      wait_edges(LAT + 3);
      @(negedge clk);
      check_level("release_level", 2'b00);

      // 1b. Asynchronous reset mid-cycle while both levels are 1.
      set_keys(2'b11);
      expect_strobe(2'b11, 2'b00, 2'b11);
      wait_edges(LAT + 3);
      @(negedge clk);
      check_level("pre_async", 2'b11);
      #3 rst_n = 1'b0;
      #1 check_all_zero("async_clear");
      key_in = 2'b00 ^ POL;
      wait_edges(2);
      @(negedge clk);
      #1 rst_n = 1'b1;
      wait_edges(3);

      // 6. Reset pulse at edge 6 of a press; key re-qualified from zero.
      set_keys(2'b01);
      wait_edges(6);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midcnt_rst");
      @(negedge clk);
      #1 rst_n = 1'b1;
      expect_strobe(2'b01, 2'b00, 2'b01);
      wait_edges(LAT - 1);
      @(negedge clk);
      check_level("requal_edge_before", 2'b00);
      wait_edges(4);
      @(negedge clk);
      check_level("requal_level", 2'b01);

      // Final report.
      wait_edges(2);
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_key_debounce
